// File: rtl/button_pkg.sv
// Shared definitions for the button capture block: colour codes, read-word layout, MMIO map.
package button_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned NUM_BUTTONS = 4;
   localparam int unsigned COLOR_W     = 2;

   typedef enum logic [COLOR_W-1:0] {
      COLOR_RED    = 2'd0,
      COLOR_BLUE   = 2'd1,
      COLOR_GREEN  = 2'd2,
      COLOR_YELLOW = 2'd3
   } color_e;

   localparam int unsigned RD_VALID_BIT   = 0;
   localparam int unsigned RD_COLOR_LSB   = 1;
   localparam int unsigned RD_OVERRUN_BIT = 3;

   typedef enum logic [11:0] {
      ADDR_RANDOM = 12'd5,
      ADDR_LED    = 12'd6,
      ADDR_BUTTON = 12'd7
   } mmio_addr_e;

   // Colour field is masked while no event is pending so an idle read is all zeros.
   function automatic logic [DATA_W-1:0] pack_read_word(input logic   valid_bit,
                                                        input color_e color_code,
                                                        input logic   overrun_bit);
      logic [DATA_W-1:0] word;
      word                               = '0;
      word[RD_VALID_BIT]                 = valid_bit;
      word[RD_COLOR_LSB +: COLOR_W]      = valid_bit ? color_code : COLOR_RED;
      word[RD_OVERRUN_BIT]               = overrun_bit;
      return word;
   endfunction

endpackage

// File: rtl/button_capture_if.sv
// Processor-side read port of the button capture block.
interface button_capture_if;
   import button_pkg::*;

   logic                   rd_en;
   logic [DATA_W-1:0]      read_data;
   logic [NUM_BUTTONS-1:0] held;
   logic                   press_pulse;

   modport master (output rd_en, input read_data, input held, input press_pulse);
   modport slave  (input rd_en, output read_data, output held, output press_pulse);

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a counter-based debouncer for one raw button.
module debounce_sync #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam logic [0:0]       STABLE_0 = 1'b0;
   localparam logic [0:0]       STABLE_1 = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             sampled;
   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], raw};
      end
   end

   assign sampled = sync[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= STABLE_0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Any cycle where the input agrees with the stable level restarts the count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         STABLE_0: begin
            if (sampled) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = STABLE_1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         STABLE_1: begin
            if (!sampled) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = STABLE_0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: state_nxt = STABLE_0;
      endcase
   end

   assign level = state[0];

endmodule

// File: rtl/button_capture.sv
// Memory-mapped button stage: debounce four buttons, detect presses, hold one event until read.
module button_capture
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             red_button,
   input  logic             blue_button,
   input  logic             green_button,
   input  logic             yellow_button,
   button_capture_if.slave  bus
);

   logic [NUM_BUTTONS-1:0] raw;
   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] level_d;
   logic [NUM_BUTTONS-1:0] press;
   logic                   any_press;
   logic                   multi_press;
   color_e                 win_color;

   logic   valid;
   logic   valid_nxt;
   color_e color;
   color_e color_nxt;
   logic   overrun;
   logic   overrun_nxt;
   logic   press_pulse;

   assign raw = {yellow_button, green_button, blue_button, red_button};

   for (genvar i = 0; i < int'(NUM_BUTTONS); i++) begin : g_btn
      debounce_sync #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clock (clock),
         .reset (reset),
         .raw   (raw[i]),
         .level (level[i])
      );
   end

   // Only rising edges of the debounced level are events; releases are ignored.
   assign press     = level & ~level_d;
   assign any_press = |press;

   // Fixed priority red > blue > green > yellow; any loser flags overrun.
   always_comb begin
      win_color   = COLOR_RED;
      multi_press = 1'b0;
      if (press[0]) begin
         win_color   = COLOR_RED;
         multi_press = |press[3:1];
      end else if (press[1]) begin
         win_color   = COLOR_BLUE;
         multi_press = |press[3:2];
      end else if (press[2]) begin
         win_color   = COLOR_GREEN;
         multi_press = press[3];
      end else if (press[3]) begin
         win_color   = COLOR_YELLOW;
      end
   end

   // A read clears the event first, so a press landing on the same edge is kept.
   always_comb begin
      valid_nxt   = valid & ~bus.rd_en;
      overrun_nxt = overrun & ~bus.rd_en;
      color_nxt   = color;
      if (any_press) begin
         if (valid_nxt) begin
            overrun_nxt = 1'b1;
         end else begin
            valid_nxt = 1'b1;
            color_nxt = win_color;
         end
         if (multi_press) begin
            overrun_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_d     <= '0;
         valid       <= 1'b0;
         color       <= COLOR_RED;
         overrun     <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         level_d     <= level;
         valid       <= valid_nxt;
         color       <= color_nxt;
         overrun     <= overrun_nxt;
         press_pulse <= any_press;
      end
   end

   assign bus.read_data   = pack_read_word(valid, color, overrun);
   assign bus.held        = level;
   assign bus.press_pulse = press_pulse;

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture with a short debounce window.
module tb_button_capture;
   import button_pkg::*;

   localparam int unsigned DC = 4;
   localparam int unsigned CW = 3;

   logic clock  = 1'b0;
   logic reset  = 1'b0;
   logic red    = 1'b0;
   logic blue   = 1'b0;
   logic green  = 1'b0;
   logic yellow = 1'b0;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   button_capture_if bus ();

   button_capture #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .red_button    (red),
      .blue_button   (blue),
      .green_button  (green),
      .yellow_button (yellow),
      .bus           (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges, sampling on the following falling edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
         if (bus.press_pulse) pulses++;
      end
   endtask

   task automatic read_expect(input string tag, input logic [31:0] exp);
      bus.rd_en = 1'b1;
      #1 check(tag, bus.read_data, exp);
      step(1);
      bus.rd_en = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      bus.rd_en = 1'b0;
      #1;
      check("rst_read", bus.read_data, 32'h0);
      check("rst_held", 32'(bus.held), 32'h0);
      check("rst_pulse", 32'(bus.press_pulse), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      step(3);

      // Blue press: level at edge 6, event at edge 7, read at edge 9.
      blue = 1'b1;
      step(6);
      check("blue_e6_read", bus.read_data, 32'h0);
      check("blue_e6_held", 32'(bus.held), 32'h2);
      step(1);
      check("blue_e7_read", bus.read_data, 32'h3);
      check("blue_e7_pulse", 32'(bus.press_pulse), 32'h1);
      step(1);
      check("blue_e8_pulse", 32'(bus.press_pulse), 32'h0);
      read_expect("blue_rd", 32'h3);
      check("blue_after_rd", bus.read_data, 32'h0);
      blue = 1'b0;
      step(10);
      check("blue_release_held", 32'(bus.held), 32'h0);
      check("blue_release_read", bus.read_data, 32'h0);
      check("pulses_1", 32'(pulses), 32'd1);

      // Green glitching every cycle never settles.
      for (int i = 0; i < 20; i++) begin
         green = ~green;
         step(1);
      end
      step(10);
      check("glitch_held", 32'(bus.held), 32'h0);
      check("glitch_read", bus.read_data, 32'h0);
      check("glitch_pulses", 32'(pulses), 32'd1);

      // Red and yellow together: red wins, overrun set.
      red    = 1'b1;
      yellow = 1'b1;
      step(7);
      check("ry_read", bus.read_data, 32'h9);
      check("ry_held", 32'(bus.held), 32'h9);
      read_expect("ry_rd", 32'h9);
      check("ry_after_rd", bus.read_data, 32'h0);
      red    = 1'b0;
      yellow = 1'b0;
      step(10);
      check("ry_release_held", 32'(bus.held), 32'h0);
      check("pulses_2", 32'(pulses), 32'd2);

      // Yellow unread, then red: yellow kept, overrun sticky.
      yellow = 1'b1;
      step(7);
      check("y_read", bus.read_data, 32'h7);
      red = 1'b1;
      step(7);
      check("y_then_r_read", bus.read_data, 32'hF);
      check("pulses_4", 32'(pulses), 32'd4);
      read_expect("y_then_r_rd", 32'hF);
      check("y_then_r_after", bus.read_data, 32'h0);
      red    = 1'b0;
      yellow = 1'b0;
      step(10);

      // Read on the same edge green's press lands.
      green = 1'b1;
      step(6);
      read_expect("g_same_edge_rd", 32'h0);
      check("g_after_edge", bus.read_data, 32'h5);
      check("pulses_5", 32'(pulses), 32'd5);
      // rd_en held three cycles: only the first read returns the event.
      bus.rd_en = 1'b1;
      #1 check("hold_rd1", bus.read_data, 32'h5);
      step(1);
      check("hold_rd2", bus.read_data, 32'h0);
      step(1);
      check("hold_rd3", bus.read_data, 32'h0);
      step(1);
      bus.rd_en = 1'b0;
      green = 1'b0;
      step(10);

      // Async reset mid-count clears a pending event immediately.
      red = 1'b1;
      step(7);
      check("pre_rst_read", bus.read_data, 32'h1);
      check("pulses_6", 32'(pulses), 32'd6);
      blue = 1'b1;
      step(3);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_read", bus.read_data, 32'h0);
      check("mid_rst_held", 32'(bus.held), 32'h0);
      check("mid_rst_pulse", 32'(bus.press_pulse), 32'h0);
      red = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      step(6);
      check("post_rst_e6", bus.read_data, 32'h0);
      step(1);
      check("post_rst_e7", bus.read_data, 32'h3);
      check("pulses_7", 32'(pulses), 32'd7);
      blue = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_capture.md
Name: button_capture

Overview:
- Memory-mapped button input stage for the game SoC; sits directly upstream of the processor data-memory read mux at address 7.
- Synchronises and debounces the four raw push-buttons and detects each new press.
- Holds one pending press event until software reads it. Each read clears the event.
- The read word uses the same bit layout as the LED flash command at address 6, so software can store it straight back to light the matching LED.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz). Must be ≥1.
- CNT_W, 20, width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock (50 MHz PLL output)
- reset  input  1  asynchronous, active-low reset
- red_button  input  1  raw, asynchronous, active-high
- blue_button  input  1  raw, asynchronous, active-high
- green_button  input  1  raw, asynchronous, active-high
- yellow_button  input  1  raw, asynchronous, active-high
- rd_en  input  1  one-cycle read strobe: processor load with memAddr[11:0]==7
- read_data  output  32  {28'b0, overrun, color[1:0], valid}
- held  output  4  debounced levels {yellow, green, blue, red}
- press_pulse  output  1  one-cycle strobe whenever any new press is accepted

Behaviour:
- Reset: the clock and reset ports are named clock and reset; reset is asynchronous and active-low, with one clock.
- While reset is low, all flops clear: synchronisers, counters, debounced levels, valid, color, overrun, press_pulse. Resulting outputs: read_data=0, held=0, press_pulse=0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button, levels STABLE_0 / STABLE_1:
  - The counter clears whenever the synchronised input equals the stable level.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable level toggles and the counter clears.
  - A single-cycle glitch restarts the count.
- Edge detect: a press is a 0→1 transition of a debounced level. Releases generate no event.
- Latency: the first rising edge sampling a new steady raw level counts as edge 1. The press is visible on read_data.valid and press_pulse after exactly DEBOUNCE_CYCLES+3 rising edges.
- Simultaneous presses in one cycle: one event is recorded, priority red > blue > green > yellow. The losing presses set overrun.
- Color encoding: red=00, blue=01, green=10, yellow=11.
- Event register:
  - A press while valid=0 sets valid=1 and latches color.
  - A press while valid=1 keeps the original color and sets overrun=1 (sticky).
- Read: read_data is combinational from the registers, so it is valid in the same cycle as rd_en.
  - On a rising edge with rd_en=1, valid and overrun clear.
  - color holds its last value, but read_data[2:1] reads 0 whenever valid=0.
- Read and press on the same edge: the read returns the old word. After the edge, valid=1 with the new color and overrun=0, so no event is lost.
- rd_en held high for multiple cycles: each cycle is a read; the second and later reads return 0 unless a new press arrived.
- Reset mid-debounce: partial counts are discarded. A button still held after reset produces a press event DEBOUNCE_CYCLES+3 edges after reset deasserts.

Decomposition:
- Shared package button_pkg holds:
  - color codes COLOR_RED, COLOR_BLUE, COLOR_GREEN, COLOR_YELLOW
  - bit positions RD_VALID_BIT=0, RD_COLOR_LSB=1, RD_OVERRUN_BIT=3
  - MMIO addresses ADDR_RANDOM=5, ADDR_LED=6, ADDR_BUTTON=7
- Sub-module debounce_sync (synchroniser + counter + debounced level), instantiated four times. Parameters: DEBOUNCE_CYCLES, CNT_W.
- The top level holds edge detect, priority encoder and event register.

Test Plan (DEBOUNCE_CYCLES=4):
- Blue high steady from edge 1 → press_pulse=1 and read_data=32'h3 at edge 7. The read at edge 9 returns 32'h3; afterwards read_data=0.
- Green toggles every cycle for 20 cycles, then returns low → no press_pulse, held=0, read_data stays 0.
- Red and yellow rise on the same cycle → read_data=32'h9 (valid, red, overrun); after a read, 0.
- Yellow press unread, then a red press → read_data=32'hF (yellow kept, overrun=1).
- rd_en on the same edge green's press is accepted → the read returns 0; the next cycle read_data=32'h5.
- reset pulled low while blue is held at mid-count → outputs 0 immediately (asynchronous). After release, 32'h3 appears exactly 7 edges later.
